// File: rtl/cmul_pkg.sv
// Shared definitions for the complex-multiplier sequencer: FSM state encoding
// and add/sub select codes.
package cmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_AC  = 3'd1,
    S_BD  = 3'd2,
    S_AD  = 3'd3,
    S_BC  = 3'd4,
    S_OUT = 3'd5
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cmul_addsub.sv
// Two's complement add/subtract built from 4-bit carry-lookahead groups.
// Subtraction inverts b and injects a carry of 1 into the lowest group.
module cmul_addsub
  import cmul_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] y
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0]    bx;
  logic [W-1:0]    g;
  logic [W-1:0]    p;
  logic [W-1:0]    c;
  logic [NG-1:0]   gc;
  logic [NG-2:0]   grp_g;
  logic [NG-2:0]   grp_p;

  always_comb begin
    bx = (op == OP_SUB) ? ~b : b;
    g  = a & bx;
    p  = a ^ bx;

    // Group generate/propagate; the top group's carry-out is never needed.
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NG - 1; k++) begin
      grp_p[k] = 1'b1;
      for (int j = 4 * k; j < 4 * k + 4; j++) begin
        grp_g[k] = g[j] | (p[j] & grp_g[k]);
        grp_p[k] = grp_p[k] & p[j];
      end
    end

    gc    = '0;
    gc[0] = (op == OP_SUB);
    for (int k = 1; k < NG; k++) begin
      gc[k] = grp_g[k-1] | (grp_p[k-1] & gc[k-1]);
    end

    c = '0;
    for (int i = 0; i < W; i++) begin
      if (i % 4 == 0) begin
        c[i] = gc[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end

    y = p ^ c;
  end

endmodule

// File: rtl/cmul_seq_ctrl.sv
// Complex multiply sequencer sharing one external multiplier and one add/sub unit.
// Optional CMUL_CONJ_EN adds in_conj, selecting A*conj(B) per operation.
module cmul_seq_ctrl
  import cmul_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid is held with stable data until that edge.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   ar,
  input  logic [DW-1:0]   ai,
  input  logic [DW-1:0]   br,
  input  logic [DW-1:0]   bi,
`ifdef CMUL_CONJ_EN
  input  logic            in_conj,
`endif
  output logic [DW-1:0]   mul_x,
  output logic [DW-1:0]   mul_y,
  input  logic [2*DW-1:0] mul_p,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW:0]   re,
  output logic [2*DW:0]   im,
  output logic [15:0]     op_count,
  output state_t          dbg_state
);

  localparam int RW = 2 * DW + 1;

  state_t        state;
  logic [DW-1:0] ar_q;
  logic [DW-1:0] ai_q;
  logic [DW-1:0] br_q;
  logic [DW-1:0] bi_q;
  logic          conj_q;
  logic [RW-1:0] acc_a;
  logic [RW-1:0] prod_ext;
  logic [RW-1:0] sum;
  logic          op_sel;

`ifndef CMUL_CONJ_EN
  assign conj_q = 1'b0;
`endif

  assign prod_ext  = {mul_p[2*DW-1], mul_p};
  assign dbg_state = state;

  // First step of each part starts from zero; conjugate flips the sign of bd and ad.
  always_comb begin
    acc_a  = '0;
    op_sel = OP_ADD;
    case (state)
      S_BD: begin
        acc_a  = re;
        op_sel = conj_q ? OP_ADD : OP_SUB;
      end
      S_AD:    op_sel = conj_q ? OP_SUB : OP_ADD;
      S_BC:    acc_a  = im;
      default: ;
    endcase
  end

  cmul_addsub #(.W(RW)) u_addsub (
    .a  (acc_a),
    .b  (prod_ext),
    .op (op_sel),
    .y  (sum)
  );

  // Multiplier operands are registered one step ahead so mul_p matches the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      re        <= '0;
      im        <= '0;
      op_count  <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      ar_q      <= '0;
      ai_q      <= '0;
      br_q      <= '0;
      bi_q      <= '0;
`ifdef CMUL_CONJ_EN
      conj_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ar_q     <= ar;
            ai_q     <= ai;
            br_q     <= br;
            bi_q     <= bi;
`ifdef CMUL_CONJ_EN
            conj_q   <= in_conj;
`endif
            mul_x    <= ar;
            mul_y    <= br;
            in_ready <= 1'b0;
            state    <= S_AC;
          end
        end
        S_AC: begin
          re    <= sum;
          mul_x <= ai_q;
          mul_y <= bi_q;
          state <= S_BD;
        end
        S_BD: begin
          re    <= sum;
          mul_x <= ar_q;
          mul_y <= bi_q;
          state <= S_AD;
        end
        S_AD: begin
          im    <= sum;
          mul_x <= ai_q;
          mul_y <= br_q;
          state <= S_BC;
        end
        S_BC: begin
          im        <= sum;
          mul_x     <= '0;
          mul_y     <= '0;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          mul_x     <= '0;
          mul_y     <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
